// File: rtl/reg_file_sb.sv
// Register file with per-register pending-write scoreboard and a one-entry-per-cycle clear sweep.
// Optional macro REG_FILE_BYPASS_EN forwards the current-cycle writeback onto the read ports.
module reg_file_sb #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            w_en,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] rdv,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            alloc_en,
  input  logic [AW-1:0]   alloc_rd,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            clr_req,
  output logic            clr_busy,
  output logic            clr_done
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_e;

  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            idle, wr_ok, al_ok;

  // Nonzero and inside the file (matters only for non-power-of-2 NREG).
  function automatic logic valid_idx(input logic [AW-1:0] i);
    return (i != '0) && ({1'b0, i} < NREG_W);
  endfunction

  assign idle  = (state_q == IDLE);
  assign wr_ok = idle && w_en && valid_idx(rd);
  assign al_ok = idle && alloc_en && valid_idx(alloc_rd);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    clr_busy = (state_q != IDLE);
    clr_done = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          idx_d   = AW'(1);
        end
      end
      SWEEP: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NREG - 1)) begin
          state_d = DONE;
          idx_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Alloc is applied after the write so a same-index collision leaves busy set.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (state_q == SWEEP) begin
      regs_d[idx_q] = '0;
      busy_d[idx_q] = 1'b0;
    end
    if (wr_ok) begin
      regs_d[rd] = rdv;
      busy_d[rd] = 1'b0;
    end
    if (al_ok) begin
      busy_d[alloc_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      regs_q  <= regs_d;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (idle && valid_idx(rs1)) begin
      rs1_data = regs_q[rs1];
      rs1_busy = busy_q[rs1];
    end
    if (idle && valid_idx(rs2)) begin
      rs2_data = regs_q[rs2];
      rs2_busy = busy_q[rs2];
    end
`ifdef REG_FILE_BYPASS_EN
    if (wr_ok && (rd == rs1)) begin
      rs1_data = rdv;
      rs1_busy = 1'b0;
    end
    if (wr_ok && (rd == rs2)) begin
      rs2_data = rdv;
      rs2_busy = 1'b0;
    end
`endif
  end

endmodule
